uart_tx_cfg: RTL and testbench

Parametrised UART transmitter and the successor to the fixed 8N1 transmitter. It has configurable data width, parity mode and stop-bit count. It uses a valid/ready handshake instead of change-detection on the input byte, so repeated identical bytes are sent. It sits between host/protocol logic and the FPGA TX pin, one instance per serial channel.

---
 rtl/uart_tx_cfg.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter (data width, parity, stop bits) with valid/ready input.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
`ifdef UART_TX_BREAK_EN
    input  logic                 i_TX_Break,
`endif
    input  logic [DATA_BITS-1:0] i_TX_Data,
    input  logic                 i_TX_DV,
    output logic                 o_TX_Ready,
    output logic                 o_TX_Serial,
    output logic                 o_TX_Active,
    output logic                 o_TX_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 parity_bit, parity_n;
    logic                 serial_n, ready_n, active_n, done_n;
    logic                 bit_end;
    logic                 brk;

`ifdef UART_TX_BREAK_EN
    assign brk = i_TX_Break;
`else
    assign brk = 1'b0;
`endif

    assign bit_end = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            parity_bit  <= 1'b0;
            o_TX_Serial <= 1'b1;
            o_TX_Ready  <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            state       <= state_n;
            clk_cnt     <= clk_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            parity_bit  <= parity_n;
            o_TX_Serial <= serial_n;
            o_TX_Ready  <= ready_n;
            o_TX_Active <= active_n;
            o_TX_Done   <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        parity_n  = parity_bit;
        serial_n  = o_TX_Serial;
        done_n    = 1'b0;

        case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                serial_n  = 1'b1;
                // Break outranks a pending valid; accept uses the registered ready flag.
                if (brk) begin
                    serial_n = 1'b0;
                end else if (i_TX_DV && o_TX_Ready) begin
                    shift_n  = i_TX_Data;
                    parity_n = (PARITY_MODE == 1) ? ~^i_TX_Data : ^i_TX_Data;
                    state_n  = S_START;
                    serial_n = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = S_DATA;
                    serial_n  = shift[0];
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
                        if (PARITY_MODE != 0) begin
                            state_n  = S_PARITY;
                            serial_n = parity_bit;
                        end else begin
                            state_n  = S_STOP;
                            serial_n = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                        shift_n   = shift >> 1;
                        serial_n  = shift[1];
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = S_STOP;
                    serial_n  = 1'b1;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                serial_n = 1'b1;
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = S_IDLE;
                        done_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n  = S_IDLE;
                serial_n = 1'b1;
            end
        endcase

        // A break seen only on the completion edge must not hide the completion-cycle ready.
        ready_n  = (state_n == S_IDLE) && !((state == S_IDLE) && brk);
        active_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: three parameterisations driven with random payloads
// and compared cycle by cycle against a bit-sequence reference model.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dv  = '0;
    logic [2:0] brk = '0;
    logic [7:0] d0  = '0;
    logic [6:0] d1  = '0;
    logic [7:0] d2  = '0;
    logic [2:0] ser, rdy, act, dn;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
        .i_Clock(clk), .i_Reset(rst),
`ifdef UART_TX_BREAK_EN
        .i_TX_Break(brk[0]),
`endif
        .i_TX_Data(d0), .i_TX_DV(dv[0]), .o_TX_Ready(rdy[0]),
        .o_TX_Serial(ser[0]), .o_TX_Active(act[0]), .o_TX_Done(dn[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u1 (
        .i_Clock(clk), .i_Reset(rst),
`ifdef UART_TX_BREAK_EN
        .i_TX_Break(brk[1]),
`endif
        .i_TX_Data(d1), .i_TX_DV(dv[1]), .o_TX_Ready(rdy[1]),
        .o_TX_Serial(ser[1]), .o_TX_Active(act[1]), .o_TX_Done(dn[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(3), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u2 (
        .i_Clock(clk), .i_Reset(rst),
`ifdef UART_TX_BREAK_EN
        .i_TX_Break(brk[2]),
`endif
        .i_TX_Data(d2), .i_TX_DV(dv[2]), .o_TX_Ready(rdy[2]),
        .o_TX_Serial(ser[2]), .o_TX_Active(act[2]), .o_TX_Done(dn[2]));

    function automatic int cfg_c(input int i);
        return (i == 2) ? 3 : 4;
    endfunction
    function automatic int cfg_d(input int i);
        return (i == 1) ? 7 : 8;
    endfunction
    function automatic int cfg_p(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction
    function automatic int cfg_s(input int i);
        return (i == 1) ? 2 : 1;
    endfunction
    function automatic int frame_len(input int i);
        return 1 + cfg_d(i) + ((cfg_p(i) != 0) ? 1 : 0) + cfg_s(i);
    endfunction

    // Expected line level j cycles after the accept edge, from the frame layout.
    function automatic logic exp_line(input int i, input logic [8:0] v, input int j);
        int b, ones;
        b = j / cfg_c(i);
        ones = 0;
        for (int k = 0; k < cfg_d(i); k++) ones += int'(v[k]);
        if (b == 0) return 1'b0;
        if (b <= cfg_d(i)) return v[b-1];
        if (cfg_p(i) != 0 && b == cfg_d(i) + 1)
            return (cfg_p(i) == 1) ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
        return 1'b1;
    endfunction

    task automatic set_data(input int i, input logic [8:0] v);
        case (i)
            0: d0 = v[7:0];
            1: d1 = v[6:0];
            default: d2 = v[7:0];
        endcase
    endtask

    function automatic logic [8:0] rnd_data(input int i);
        logic [8:0] r;
        r = 9'($urandom);
        return (cfg_d(i) == 7) ? (r & 9'h07F) : (r & 9'h0FF);
    endfunction

    // Entered #1 after an edge with ready high; drives one frame and checks every cycle.
    task automatic run_frame(input int i, input logic [8:0] v, input bit hold,
                             input bit pulse, input int abort_at);
        int total;
        logic [3:0] got, want;
        total = frame_len(i) * cfg_c(i);
        set_data(i, v);
        dv[i] = 1'b1;
        for (int j = 0; j <= total; j++) begin
            @(posedge clk); #1;
            set_data(i, rnd_data(i));
            if (!hold) dv[i] = pulse && (j == total / 2);
            got  = {ser[i], rdy[i], act[i], dn[i]};
            want = (j < total) ? {exp_line(i, v, j), 3'b010} : 4'b1101;
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL frame u%0d data=%h cycle=%0d {ser,rdy,act,done} got=%b want=%b",
                         i, v, j, got, want);
            end
            if (abort_at > 0 && j == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                got = {ser[i], rdy[i], act[i], dn[i]};
                n_cmp++;
                if (got !== 4'b1100) begin
                    n_err++;
                    $display("FAIL abort u%0d {ser,rdy,act,done} got=%b want=1100", i, got);
                end
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ser, rdy, act, dn} !== {3'b111, 3'b111, 3'b000, 3'b000}) begin
            n_err++;
            $display("FAIL reset_hold ser/rdy/act/done got=%b_%b_%b_%b want=111_111_000_000",
                     ser, rdy, act, dn);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({ser, rdy, act, dn} !== {3'b111, 3'b111, 3'b000, 3'b000}) begin
            n_err++;
            $display("FAIL reset_release ser/rdy/act/done got=%b_%b_%b_%b want=111_111_000_000",
                     ser, rdy, act, dn);
        end
    endtask

    task automatic test_8n1();
        run_frame(0, 9'h0A5, 1'b0, 1'b0, 0);
        for (int n = 0; n < 3; n++) run_frame(0, rnd_data(0), 1'b0, 1'b0, 0);
        run_frame(0, 9'h000, 1'b0, 1'b0, 0);
        run_frame(0, 9'h0FF, 1'b0, 1'b0, 0);
    endtask

    task automatic test_even_parity_2stop();
        run_frame(1, 9'h045, 1'b0, 1'b0, 0);
        for (int n = 0; n < 3; n++) run_frame(1, rnd_data(1), 1'b0, 1'b0, 0);
    endtask

    task automatic test_odd_parity();
        run_frame(2, 9'h000, 1'b0, 1'b0, 0);
        run_frame(2, 9'h001, 1'b0, 1'b0, 0);
        for (int n = 0; n < 3; n++) run_frame(2, rnd_data(2), 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_frame(0, 9'h055, 1'b1, 1'b0, 0);
        run_frame(0, 9'h055, 1'b0, 1'b0, 0);
        run_frame(0, rnd_data(0), 1'b0, 1'b1, 0);
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ser[0], rdy[0], act[0], dn[0]} !== 4'b1100) begin
                n_err++;
                $display("FAIL no_queue cycle=%0d {ser,rdy,act,done} got=%b want=1100",
                         n, {ser[0], rdy[0], act[0], dn[0]});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(0, rnd_data(0), 1'b0, 1'b0, 4 * 4 + 2);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ser[0], rdy[0], act[0], dn[0]} !== 4'b1100) begin
                n_err++;
                $display("FAIL post_abort cycle=%0d {ser,rdy,act,done} got=%b want=1100",
                         n, {ser[0], rdy[0], act[0], dn[0]});
            end
        end
        run_frame(0, 9'h03C, 1'b0, 1'b0, 0);
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        logic [8:0] v;
        v = rnd_data(0);
        set_data(0, v);
        dv[0]  = 1'b1;
        brk[0] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ser[0], rdy[0], act[0], dn[0]} !== 4'b0000) begin
                n_err++;
                $display("FAIL break cycle=%0d {ser,rdy,act,done} got=%b want=0000",
                         n, {ser[0], rdy[0], act[0], dn[0]});
            end
        end
        brk[0] = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({ser[0], rdy[0], act[0], dn[0]} !== 4'b1100) begin
            n_err++;
            $display("FAIL break_release {ser,rdy,act,done} got=%b want=1100",
                     {ser[0], rdy[0], act[0], dn[0]});
        end
        run_frame(0, v, 1'b0, 1'b0, 0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1();
        test_even_parity_2stop();
        test_odd_parity();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
